eb1_lsu_ecc_wb: RTL

ECC correction write-back queue, directly downstream of the LSU ECC decode stage. Captures R-stage single-bit-corrected DCCM load data with its bank addresses. Queues up to DEPTH corrections and arbitrates for the DCCM write port to scrub the faulty words back to memory. ECC bits are regenerated on the outgoing data, so the DCCM write mux needs no extra encoder.

---
 rtl/eb1_lsu_ecc_wb_pkg.sv | 32 +++
 rtl/eb1_lsu_ecc_wb_fifo.sv | 58 +++++
 rtl/rvecc_encode.sv | 32 +++
 rtl/eb1_lsu_ecc_wb.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/eb1_lsu_ecc_wb_pkg.sv
// ---------------------------------------------------------------------------
// eb1_lsu_ecc_wb_pkg
// Shared types for the LSU ECC correction write-back queue:
//   eb1_ecc_wb_entry_t  - one queued correction (bank addresses, data, fixes)
//   eb1_ecc_wb_state_e  - write-port request FSM states
//   sat_inc16()         - saturating increment for the corrected-error count
// ---------------------------------------------------------------------------
package eb1_lsu_ecc_wb_pkg;

   localparam int unsigned ECC_WB_ADDR_W = 16;
   localparam int unsigned ECC_WB_DATA_W = 32;

   typedef struct packed {
      logic [ECC_WB_ADDR_W-1:0] addr_hi;
      logic [ECC_WB_ADDR_W-1:0] addr_lo;
      logic [ECC_WB_DATA_W-1:0] data_hi;
      logic [ECC_WB_DATA_W-1:0] data_lo;
      logic                     fix_hi;
      logic                     fix_lo;
   } eb1_ecc_wb_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      TURN = 2'd2
   } eb1_ecc_wb_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/eb1_lsu_ecc_wb_fifo.sv
// ---------------------------------------------------------------------------
// eb1_lsu_ecc_wb_fifo
// Generic entry FIFO for the ECC write-back queue.
//   clk, rst_l        - clock, async active-low reset
//   push_i / wdata_i  - enqueue an entry (caller guarantees room)
//   pop_i             - drop the head entry (caller guarantees non-empty)
//   rdata_o           - head entry
//   full_o / empty_o  - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module eb1_lsu_ecc_wb_fifo #(
   parameter type         entry_t = logic,
   parameter int unsigned DEPTH   = 2
) (
   input  logic   clk,
   input  logic   rst_l,
   input  logic   push_i,
   input  logic   pop_i,
   input  entry_t wdata_i,
   output entry_t rdata_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   entry_t        mem_q [DEPTH];

   always_comb begin
      wptr_d = push_i ? wptr_q + PTR_ONE : wptr_q;
      rptr_d = pop_i  ? rptr_q + PTR_ONE : rptr_q;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (push_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
         end
      end
   end

   assign rdata_o = mem_q[rptr_q[AW-1:0]];
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/rvecc_encode.sv
// ---------------------------------------------------------------------------
// rvecc_encode
// SECDED encoder for one 32-bit DCCM bank word.
//   din     - data word
//   ecc_out - [5:0] Hamming check bits, [6] overall parity over data and checks
// Data bits occupy the non-power-of-two Hamming positions 3,5,6,7,9,... in
// ascending order; check bit k covers every position with bit k set.
// ---------------------------------------------------------------------------
module rvecc_encode (
   input  logic [31:0] din,
   output logic [6:0]  ecc_out
);

   logic [5:0] chk;
   logic [5:0] pos;
   logic [4:0] didx;

   always_comb begin
      chk  = '0;
      pos  = '0;
      didx = '0;
      for (int p = 1; p <= 38; p++) begin
         pos = 6'(p);
         if ((pos & (pos - 6'd1)) != 6'd0) begin
            chk  = chk ^ ({6{din[didx]}} & pos);
            didx = didx + 5'd1;
         end
      end
      ecc_out = {(^din) ^ (^chk), chk};
   end

endmodule

// File: rtl/eb1_lsu_ecc_wb.sv
// ---------------------------------------------------------------------------
// eb1_lsu_ecc_wb
// ECC correction write-back queue. Captures single-bit-corrected DCCM load
// data from the R stage, queues up to DEPTH corrections and requests the DCCM
// write port to scrub them back, with ECC regenerated on the outgoing data.
// Inputs : clk, rst_l, dec_tlu_core_ecc_disable, ld_single_ecc_error_r,
//          lsu_double_ecc_error_r, single_ecc_error_{hi,lo}_r, lsu_addr_r,
//          end_addr_r, sec_data_{hi,lo}_r, ecc_wb_gnt
// Outputs: ecc_wb_req, ecc_wb_wen_{hi,lo}, ecc_wb_addr_{hi,lo},
//          ecc_wb_data_{hi,lo}, ecc_wb_ecc_{hi,lo}, ecc_wb_pending,
//          ecc_wb_overflow, ecc_err_cnt, ecc_err_last_addr
// Optional: LSU_ECC_ERRLOG_EN adds the corrected-error counter and last
//           corrected address; without it both outputs are tied to 0.
// ---------------------------------------------------------------------------
module eb1_lsu_ecc_wb
   import eb1_lsu_ecc_wb_pkg::*;
#(
   parameter int unsigned DCCM_BITS       = ECC_WB_ADDR_W,
   parameter int unsigned DCCM_DATA_WIDTH = ECC_WB_DATA_W,
   parameter int unsigned DCCM_ECC_WIDTH  = 7,
   parameter int unsigned DEPTH           = 2
) (
   input  logic                       clk,
   input  logic                       rst_l,
   input  logic                       dec_tlu_core_ecc_disable,
   input  logic                       ld_single_ecc_error_r,
   input  logic                       lsu_double_ecc_error_r,
   input  logic                       single_ecc_error_hi_r,
   input  logic                       single_ecc_error_lo_r,
   input  logic [DCCM_BITS-1:0]       lsu_addr_r,
   input  logic [DCCM_BITS-1:0]       end_addr_r,
   input  logic [DCCM_DATA_WIDTH-1:0] sec_data_hi_r,
   input  logic [DCCM_DATA_WIDTH-1:0] sec_data_lo_r,
   input  logic                       ecc_wb_gnt,
   output logic                       ecc_wb_req,
   output logic                       ecc_wb_wen_hi,
   output logic                       ecc_wb_wen_lo,
   output logic [DCCM_BITS-1:0]       ecc_wb_addr_hi,
   output logic [DCCM_BITS-1:0]       ecc_wb_addr_lo,
   output logic [DCCM_DATA_WIDTH-1:0] ecc_wb_data_hi,
   output logic [DCCM_DATA_WIDTH-1:0] ecc_wb_data_lo,
   output logic [DCCM_ECC_WIDTH-1:0]  ecc_wb_ecc_hi,
   output logic [DCCM_ECC_WIDTH-1:0]  ecc_wb_ecc_lo,
   output logic                       ecc_wb_pending,
   output logic                       ecc_wb_overflow,
   output logic [15:0]                ecc_err_cnt,
   output logic [DCCM_BITS-1:0]       ecc_err_last_addr
);

   eb1_ecc_wb_entry_t enq_entry, head;
   eb1_ecc_wb_state_e state_q, state_d;
   logic              full, empty;
   logic              enq_req, push, pop, same_bank;
   logic              overflow_q;

   assign enq_entry = '{addr_hi: end_addr_r,
                        addr_lo: lsu_addr_r,
                        data_hi: sec_data_hi_r,
                        data_lo: sec_data_lo_r,
                        fix_hi:  single_ecc_error_hi_r,
                        fix_lo:  single_ecc_error_lo_r};

   // A correction with neither bank flagged has nothing to scrub.
   assign enq_req = ld_single_ecc_error_r & ~lsu_double_ecc_error_r &
                    ~dec_tlu_core_ecc_disable &
                    (single_ecc_error_hi_r | single_ecc_error_lo_r);
   assign pop     = (state_q == REQ) & ecc_wb_gnt;
   // A pop in the same cycle frees the slot the new entry needs.
   assign push    = enq_req & (~full | pop);

   eb1_lsu_ecc_wb_fifo #(
      .entry_t (eb1_ecc_wb_entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_l   (rst_l),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (enq_entry),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (!empty || push) state_d = REQ;
         REQ:     if (ecc_wb_gnt) state_d = TURN;
         TURN:    state_d = (!empty || push) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= IDLE;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         overflow_q <= overflow_q | (enq_req & full & ~pop);
      end
   end

   // Both addresses in one bank word: the whole access lives in the lo bank.
   assign same_bank = (head.addr_lo[2] == head.addr_hi[2]);

   always_comb begin
      ecc_wb_req     = (state_q == REQ);
      ecc_wb_wen_hi  = ecc_wb_req & head.fix_hi & ~same_bank;
      ecc_wb_wen_lo  = ecc_wb_req & (head.fix_lo | (head.fix_hi & same_bank));
      ecc_wb_addr_hi = ecc_wb_req ? head.addr_hi : '0;
      ecc_wb_addr_lo = ecc_wb_req ? head.addr_lo : '0;
      ecc_wb_data_hi = ecc_wb_req ? head.data_hi : '0;
      ecc_wb_data_lo = ecc_wb_req ? head.data_lo : '0;
      ecc_wb_pending = ~empty | (state_q != IDLE);
   end

   assign ecc_wb_overflow = overflow_q;

   rvecc_encode u_ecc_hi (
      .din     (ecc_wb_data_hi),
      .ecc_out (ecc_wb_ecc_hi)
   );

   rvecc_encode u_ecc_lo (
      .din     (ecc_wb_data_lo),
      .ecc_out (ecc_wb_ecc_lo)
   );

`ifdef LSU_ECC_ERRLOG_EN
   logic [15:0]          err_cnt_q;
   logic [DCCM_BITS-1:0] err_addr_q;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         err_cnt_q  <= '0;
         err_addr_q <= '0;
      end else if (push) begin
         err_cnt_q  <= sat_inc16(err_cnt_q);
         err_addr_q <= single_ecc_error_lo_r ? lsu_addr_r : end_addr_r;
      end
   end

   assign ecc_err_cnt       = err_cnt_q;
   assign ecc_err_last_addr = err_addr_q;
`else
   assign ecc_err_cnt       = '0;
   assign ecc_err_last_addr = '0;
`endif

endmodule
